writeback_stage: RTL and testbench

//  Write-back (WB) stage of the 5-stage RV32I pipeline; drives the register-file write port.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/load_aligner.sv | 40 ++++
 rtl/writeback_stage.sv | 143 ++++++++++++++
 tb/tb_writeback_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline types: write-back result select, load funct3 codes, WB FSM states.
package rv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_aligner.sv
// Combinational load alignment: picks byte/halfword/word from an aligned memory word and extends it.
module load_aligner
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[7:0];
    case (off_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    // Halfword offset bit 0 is deliberately ignored (misaligned halves fold down).
    w_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  data_o = {24'h0, w_byte};
      F3_LH:   data_o = {{16{w_half[15]}}, w_half};
      F3_LHU:  data_o = {16'h0, w_half};
      F3_LW:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RV32I write-back stage: waits on load responses, selects the result, issues one RF write per instruction.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter on instret_o.
//
// state     | meaning
// IDLE      | nothing pending, ready for MEM
// WAIT_LOAD | load accepted, waiting for dmem_rvalid_i; MEM stalled
// WRITE     | result presented to the register file for one cycle
module writeback_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MEM_valid_i,
  output logic              MEM_ready_o,
  input  logic              MEM_reg_wr_en_i,
  input  logic [REG_AW-1:0] MEM_rd_i,
  input  logic [1:0]        MEM_wb_sel_i,
  input  logic [XLEN-1:0]   MEM_alu_result_i,
  input  logic [XLEN-1:0]   MEM_pc_plus4_i,
  input  logic [2:0]        MEM_funct3_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              WB_reg_wr_en_o,
  output logic [REG_AW-1:0] WB_rd_o,
  output logic [XLEN-1:0]   WB_wr_data_o,
  output logic              WB_busy_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]       instret_o
`endif
);

  wb_state_e r_state, w_state_nxt;

  logic              w_accept;
  logic              w_is_load;
  logic              w_load_done;
  logic [XLEN-1:0]   w_result;
  logic [XLEN-1:0]   w_load_data;

  logic              r_wr;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_data;

  logic              r_ld_wr;
  logic [REG_AW-1:0] r_ld_rd;
  logic [2:0]        r_ld_f3;
  logic [1:0]        r_ld_off;

  assign w_accept    = MEM_valid_i && MEM_ready_o;
  assign w_is_load   = (MEM_wb_sel_i == WB_LOAD);
  assign w_load_done = (r_state == WAIT_LOAD) && dmem_rvalid_i;
  // Reserved select value 3 falls through to the ALU result.
  assign w_result    = (MEM_wb_sel_i == WB_PC4) ? MEM_pc_plus4_i : MEM_alu_result_i;

  load_aligner #(.XLEN(XLEN)) u_load_aligner (
    .rdata_i  (dmem_rdata_i),
    .off_i    (r_ld_off),
    .funct3_i (r_ld_f3),
    .data_o   (w_load_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    MEM_ready_o = 1'b1;
    WB_busy_o   = 1'b0;
    case (r_state)
      IDLE, WRITE: begin
        if (w_accept) begin
          w_state_nxt = w_is_load ? WAIT_LOAD : WRITE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_LOAD: begin
        MEM_ready_o = 1'b0;
        WB_busy_o   = 1'b1;
        if (dmem_rvalid_i) begin
          w_state_nxt = WRITE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output registers only change when a new result is produced; they hold otherwise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr     <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
      r_ld_wr  <= 1'b0;
      r_ld_rd  <= '0;
      r_ld_f3  <= '0;
      r_ld_off <= '0;
    end else if (w_accept) begin
      r_ld_wr  <= MEM_reg_wr_en_i;
      r_ld_rd  <= MEM_rd_i;
      r_ld_f3  <= MEM_funct3_i;
      r_ld_off <= MEM_alu_result_i[1:0];
      if (!w_is_load) begin
        r_wr   <= MEM_reg_wr_en_i && (MEM_rd_i != '0);
        r_rd   <= MEM_rd_i;
        r_data <= w_result;
      end
    end else if (w_load_done) begin
      r_wr   <= r_ld_wr && (r_ld_rd != '0);
      r_rd   <= r_ld_rd;
      r_data <= w_load_data;
    end
  end

  assign WB_reg_wr_en_o = (r_state == WRITE) && r_wr;
  assign WB_rd_o        = r_rd;
  assign WB_wr_data_o   = r_data;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // Every instruction passes through WRITE exactly once, including suppressed writes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_instret <= '0;
    end else if (r_state == WRITE) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret_o = r_instret;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected writes queued at issue, checked by a separate monitor.
module tb_writeback_stage;
  import rv_pkg::*;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        MEM_valid_i = 1'b0;
  logic        MEM_ready_o;
  logic        MEM_reg_wr_en_i = 1'b0;
  logic [4:0]  MEM_rd_i = '0;
  logic [1:0]  MEM_wb_sel_i = '0;
  logic [31:0] MEM_alu_result_i = '0;
  logic [31:0] MEM_pc_plus4_i = '0;
  logic [2:0]  MEM_funct3_i = '0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        WB_reg_wr_en_o;
  logic [4:0]  WB_rd_o;
  logic [31:0] WB_wr_data_o;
  logic        WB_busy_o;
`ifdef WB_INSTRET_EN
  logic [63:0] instret_o;
  logic [63:0] c0;
`endif

  int n_vec = 0;
  int n_err = 0;
  wb_exp_t exp_q[$];

  writeback_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .MEM_valid_i      (MEM_valid_i),
    .MEM_ready_o      (MEM_ready_o),
    .MEM_reg_wr_en_i  (MEM_reg_wr_en_i),
    .MEM_rd_i         (MEM_rd_i),
    .MEM_wb_sel_i     (MEM_wb_sel_i),
    .MEM_alu_result_i (MEM_alu_result_i),
    .MEM_pc_plus4_i   (MEM_pc_plus4_i),
    .MEM_funct3_i     (MEM_funct3_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .WB_reg_wr_en_o   (WB_reg_wr_en_o),
    .WB_rd_o          (WB_rd_o),
    .WB_wr_data_o     (WB_wr_data_o),
    .WB_busy_o        (WB_busy_o)
`ifdef WB_INSTRET_EN
    ,
    .instret_o        (instret_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rst_i && WB_reg_wr_en_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", WB_rd_o, WB_wr_data_o);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {59'h0, WB_rd_o}, {59'h0, e.rd});
        chk("wb_data", {32'h0, WB_wr_data_o}, {32'h0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    MEM_valid_i      = 1'b1;
    MEM_reg_wr_en_i  = wr;
    MEM_rd_i         = rd;
    MEM_wb_sel_i     = sel;
    MEM_alu_result_i = alu;
    MEM_pc_plus4_i   = pc4;
    MEM_funct3_i     = f3;
    tick();
    MEM_valid_i = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [1:0] off, input logic [2:0] f3,
                         input logic [31:0] rdata, input int delay, input logic [31:0] exp);
    exp_q.push_back('{rd: rd, data: exp});
    issue(1'b1, rd, WB_LOAD, 32'h0000_1000 + {30'h0, off}, 32'h0, f3);
    for (int i = 0; i < delay; i++) begin
      chk("load_busy", {63'h0, WB_busy_o}, 64'h1);
      chk("load_ready", {63'h0, MEM_ready_o}, 64'h0);
      if (i == delay - 1) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
      end
      tick();
    end
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    chk("rst_ready", {63'h0, MEM_ready_o}, 64'h1);
    chk("rst_busy", {63'h0, WB_busy_o}, 64'h0);
    chk("rst_wr_en", {63'h0, WB_reg_wr_en_o}, 64'h0);
    chk("rst_rd", {59'h0, WB_rd_o}, 64'h0);
    chk("rst_data", {32'h0, WB_wr_data_o}, 64'h0);

    // ALU op
    exp_q.push_back('{rd: 5'd5, data: 32'h1234_5678});
    issue(1'b1, 5'd5, WB_ALU, 32'h1234_5678, 32'h0, 3'b000);
    chk("alu_wr_en", {63'h0, WB_reg_wr_en_o}, 64'h1);
    tick();
    chk("alu_one_cycle", {63'h0, WB_reg_wr_en_o}, 64'h0);

    // Loads: sign/zero extension, offsets, and reserved funct3
    do_load(5'd6, 2'd3, F3_LB, 32'h80FF_FF00, 2, 32'hFFFF_FF80);
    tick();
    do_load(5'd7, 2'd2, F3_LHU, 32'hBEEF_0001, 1, 32'h0000_BEEF);
    do_load(5'd8, 2'd2, F3_LH, 32'hBEEF_0001, 3, 32'hFFFF_BEEF);
    do_load(5'd9, 2'd1, F3_LBU, 32'h1122_A344, 1, 32'h0000_00A3);
    do_load(5'd10, 2'd3, F3_LHU, 32'h7654_3210, 1, 32'h0000_7654);
    do_load(5'd11, 2'd0, F3_LH, 32'h1234_8001, 1, 32'hFFFF_8001);
    do_load(5'd12, 2'd3, F3_LW, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
    do_load(5'd13, 2'd1, 3'b011, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
    tick();

    // Back-to-back JAL then ALU, then reserved select
    exp_q.push_back('{rd: 5'd1, data: 32'h0000_0104});
    chk("b2b_ready0", {63'h0, MEM_ready_o}, 64'h1);
    issue(1'b1, 5'd1, WB_PC4, 32'h5555_0000, 32'h0000_0104, 3'b000);
    chk("b2b_wr0", {63'h0, WB_reg_wr_en_o}, 64'h1);
    chk("b2b_ready1", {63'h0, MEM_ready_o}, 64'h1);
    exp_q.push_back('{rd: 5'd2, data: 32'hAAAA_5555});
    issue(1'b1, 5'd2, WB_ALU, 32'hAAAA_5555, 32'h0000_0200, 3'b000);
    chk("b2b_wr1", {63'h0, WB_reg_wr_en_o}, 64'h1);
    exp_q.push_back('{rd: 5'd3, data: 32'h0BAD_CAFE});
    issue(1'b1, 5'd3, 2'd3, 32'h0BAD_CAFE, 32'h0000_0300, 3'b000);
    chk("sel3_wr", {63'h0, WB_reg_wr_en_o}, 64'h1);
    tick();

    // Suppressed writes: rd=x0, and reg_wr_en=0
`ifdef WB_INSTRET_EN
    c0 = instret_o;
`endif
    issue(1'b1, 5'd0, WB_ALU, 32'h0000_00FF, 32'h0, 3'b000);
    chk("x0_wr_en", {63'h0, WB_reg_wr_en_o}, 64'h0);
    tick();
`ifdef WB_INSTRET_EN
    chk("instret_x0", instret_o, c0 + 64'd1);
`endif
    issue(1'b0, 5'd4, WB_ALU, 32'h0000_00EE, 32'h0, 3'b000);
    chk("nowr_wr_en", {63'h0, WB_reg_wr_en_o}, 64'h0);
    tick();

    // Stray rvalid in IDLE is ignored
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("stray_rvalid_wr", {63'h0, WB_reg_wr_en_o}, 64'h0);
    chk("stray_rvalid_busy", {63'h0, WB_busy_o}, 64'h0);

    // Reset while waiting on a load discards it
    issue(1'b1, 5'd14, WB_LOAD, 32'h0000_1000, 32'h0, F3_LW);
    chk("pre_rst_busy", {63'h0, WB_busy_o}, 64'h1);
    tick();
    rst_i = 1'b0;
    #2;
    chk("mid_rst_busy", {63'h0, WB_busy_o}, 64'h0);
    chk("mid_rst_ready", {63'h0, MEM_ready_o}, 64'h1);
    tick();
    rst_i = 1'b1;
    tick();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1357_9BDF;
    tick();
    dmem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_wr_en", {63'h0, WB_reg_wr_en_o}, 64'h0);
      chk("post_rst_busy", {63'h0, WB_busy_o}, 64'h0);
      chk("post_rst_ready", {63'h0, MEM_ready_o}, 64'h1);
      tick();
    end
    chk("post_rst_rd", {59'h0, WB_rd_o}, 64'h0);
    chk("post_rst_data", {32'h0, WB_wr_data_o}, 64'h0);

    tick();
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
